// File: rtl/vector_ave_pkg.sv
// Shared definitions for the vector averaging front end: FSM encoding and defaults.
package vector_ave_pkg;
   localparam int DEF_CW = 16;
   // Averager multiplier plus accumulator depth.
   localparam int DEF_RES_LAT = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } feeder_state_e;
endpackage

// File: rtl/vector_ave_feeder_res_delay.sv
// Fixed-depth single-bit delay line: turns an end-of-vector strobe into a result-valid strobe.
module res_delay #(
   parameter int RES_LAT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   logic [RES_LAT-1:0] pipe_q;
   logic [RES_LAT-1:0] pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = din;
      for (int i = 1; i < RES_LAT; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
   end

   assign dout = pipe_q[RES_LAT-1];
endmodule

// File: rtl/vector_ave_feeder.sv
// Frames an element stream into fixed-length vectors for the averager and tracks
// which averaged result is currently valid at its output.
module vector_ave_feeder
   import vector_ave_pkg::*;
#(
   parameter int RES_LAT = DEF_RES_LAT,
   parameter int CW      = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] cfg_vec_len,
   input  logic [CW-1:0] cfg_num_vec,
   input  logic [15:0]   cfg_fraction,
   input  logic          din_valid,
   input  logic [15:0]   din,
   output logic          din_ready,
   output logic          op_din_en,
   output logic          op_din_eop,
   output logic [15:0]   op_din,
   output logic [15:0]   fraction,
   output logic          res_valid,
   output logic [CW-1:0] res_idx,
   output logic          busy,
   output logic          done
);
   feeder_state_e state_q, state_d;
   logic [CW-1:0] len_q, len_d, num_q, num_d;
   logic [CW-1:0] elem_cnt_q, elem_cnt_d, vec_cnt_q, vec_cnt_d;
   logic [CW-1:0] res_idx_q, res_idx_d;
   logic [15:0]   fraction_q, fraction_d, op_din_q, op_din_d;
   logic          op_din_en_q, op_din_en_d, op_din_eop_q, op_din_eop_d;
   logic          acc, last_elem, last_vec, res_vld;

   assign acc       = din_valid && (state_q == ST_RUN);
   assign last_elem = (elem_cnt_q == len_q - CW'(1));
   assign last_vec  = (vec_cnt_q == num_q - CW'(1));

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      num_d        = num_q;
      fraction_d   = fraction_q;
      elem_cnt_d   = elem_cnt_q;
      vec_cnt_d    = vec_cnt_q;
      res_idx_d    = res_vld ? res_idx_q + CW'(1) : res_idx_q;
      op_din_en_d  = acc;
      op_din_eop_d = acc && last_elem;
      op_din_d     = acc ? din : op_din_q;
      case (state_q)
         ST_IDLE: if (start) begin
            len_d      = cfg_vec_len;
            num_d      = cfg_num_vec;
            fraction_d = cfg_fraction;
            elem_cnt_d = '0;
            vec_cnt_d  = '0;
            res_idx_d  = '0;
            state_d    = (cfg_vec_len != '0 && cfg_num_vec != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: if (acc) begin
            if (last_elem) begin
               elem_cnt_d = '0;
               vec_cnt_d  = vec_cnt_q + CW'(1);
               if (last_vec) state_d = ST_DRAIN;
            end else begin
               elem_cnt_d = elem_cnt_q + CW'(1);
            end
         end
         // Only the final result closes the job; earlier ones are still in flight.
         ST_DRAIN: if (res_vld && res_idx_q == num_q - CW'(1)) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         num_q        <= '0;
         fraction_q   <= '0;
         elem_cnt_q   <= '0;
         vec_cnt_q    <= '0;
         res_idx_q    <= '0;
         op_din_en_q  <= 1'b0;
         op_din_eop_q <= 1'b0;
         op_din_q     <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         num_q        <= num_d;
         fraction_q   <= fraction_d;
         elem_cnt_q   <= elem_cnt_d;
         vec_cnt_q    <= vec_cnt_d;
         res_idx_q    <= res_idx_d;
         op_din_en_q  <= op_din_en_d;
         op_din_eop_q <= op_din_eop_d;
         op_din_q     <= op_din_d;
      end
   end

   res_delay #(.RES_LAT(RES_LAT)) u_res_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (op_din_eop_q),
      .dout (res_vld)
   );

   assign din_ready  = (state_q == ST_RUN);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign op_din_en  = op_din_en_q;
   assign op_din_eop = op_din_eop_q;
   assign op_din     = op_din_q;
   assign fraction   = fraction_q;
   assign res_valid  = res_vld;
   assign res_idx    = res_idx_q;
endmodule

// File: tb/tb_vector_ave_feeder.sv
// Directed bench for vector_ave_feeder with hand-computed expectations.
module tb_vector_ave_feeder;
   logic        clk, rst, start;
   logic [15:0] cfg_vec_len, cfg_num_vec, cfg_fraction;
   logic        din_valid;
   logic [15:0] din;
   logic        din_ready, op_din_en, op_din_eop, res_valid, busy, done;
   logic [15:0] op_din, fraction, res_idx;
   int          total = 0;
   int          bad = 0;

   vector_ave_feeder dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_vec_len(cfg_vec_len), .cfg_num_vec(cfg_num_vec), .cfg_fraction(cfg_fraction),
      .din_valid(din_valid), .din(din), .din_ready(din_ready),
      .op_din_en(op_din_en), .op_din_eop(op_din_eop), .op_din(op_din),
      .fraction(fraction), .res_valid(res_valid), .res_idx(res_idx),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [15:0] len, input logic [15:0] num, input logic [15:0] frac);
      cfg_vec_len  = len;
      cfg_num_vec  = num;
      cfg_fraction = frac;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      logic        v2 [5];
      logic [15:0] d2 [5];
      int          pulses;
      logic        done_seen;

      rst = 1'b1; start = 1'b0; cfg_vec_len = '0; cfg_num_vec = '0; cfg_fraction = '0;
      din_valid = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", din_ready, 0);
      chk("rst_en", op_din_en, 0);
      chk("rst_frac", fraction, 0);
      chk("rst_idx", res_idx, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      step();

      // 1: vec_len=4 num_vec=2 continuous
      go(16'd4, 16'd2, 16'h0040);
      chk("t1_busy", busy, 1);
      chk("t1_ready", din_ready, 1);
      chk("t1_frac", fraction, 16'h0040);
      for (int i = 1; i <= 8; i++) begin
         din_valid = 1'b1; din = 16'(i);
         step();
         chk("t1_en", op_din_en, 1);
         chk("t1_din", op_din, i);
         chk("t1_eop", op_din_eop, (i % 4 == 0));
         chk("t1_rv", res_valid, (i == 7));
         if (i == 7) chk("t1_idx0", res_idx, 0);
      end
      din_valid = 1'b0;
      step();
      chk("t1_ready_drain", din_ready, 0);
      chk("t1_en_off", op_din_en, 0);
      chk("t1_busy_drain", busy, 1);
      step();
      chk("t1_rv_e10", res_valid, 0);
      step();
      chk("t1_rv2", res_valid, 1);
      chk("t1_idx1", res_idx, 1);
      step();
      chk("t1_done", done, 1);
      chk("t1_rv_off", res_valid, 0);
      step();
      chk("t1_done_off", done, 0);
      chk("t1_busy_off", busy, 0);
      chk("t1_frac_hold", fraction, 16'h0040);

      // 2: vec_len=3 num_vec=1 with bubbles
      v2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      d2 = '{16'd10, 16'd10, 16'd12, 16'd12, 16'd14};
      go(16'd3, 16'd1, 16'h0055);
      for (int k = 0; k < 5; k++) begin
         din_valid = v2[k]; din = 16'(10 + k);
         step();
         chk("t2_en", op_din_en, v2[k]);
         chk("t2_eop", op_din_eop, (k == 4));
         chk("t2_din", op_din, d2[k]);
      end
      din_valid = 1'b0;
      chk("t2_ready_drain", din_ready, 0);
      step();
      chk("t2_rv_a", res_valid, 0);
      step();
      chk("t2_rv_b", res_valid, 0);
      step();
      chk("t2_rv", res_valid, 1);
      chk("t2_idx", res_idx, 0);
      step();
      chk("t2_done", done, 1);
      step();
      chk("t2_busy_off", busy, 0);

      // 3: zero-size jobs
      din_valid = 1'b1; din = 16'h1234;
      go(16'd0, 16'd3, 16'h0001);
      chk("t3_busy", busy, 1);
      chk("t3_done", done, 1);
      chk("t3_ready", din_ready, 0);
      chk("t3_en", op_din_en, 0);
      step();
      chk("t3_busy_off", busy, 0);
      chk("t3_done_off", done, 0);
      chk("t3_en2", op_din_en, 0);
      chk("t3_rv", res_valid, 0);
      go(16'd2, 16'd0, 16'h0002);
      chk("t3b_done", done, 1);
      chk("t3b_ready", din_ready, 0);
      step();
      chk("t3b_done_off", done, 0);
      chk("t3b_en", op_din_en, 0);
      din_valid = 1'b0;

      // 4: vec_len=1 num_vec=5
      go(16'd1, 16'd5, 16'h7fff);
      for (int j = 1; j <= 10; j++) begin
         din_valid = (j <= 5); din = 16'(j * 3);
         step();
         chk("t4_en", op_din_en, (j <= 5));
         chk("t4_eop", op_din_eop, (j <= 5));
         chk("t4_rv", res_valid, (j >= 4 && j <= 8));
         if (j >= 4 && j <= 8) chk("t4_idx", res_idx, j - 4);
         chk("t4_done", done, (j == 9));
         chk("t4_busy", busy, (j <= 9));
      end
      din_valid = 1'b0;

      // 5: reset mid-vector
      go(16'd4, 16'd2, 16'h0040);
      din_valid = 1'b1; din = 16'd7;
      step();
      din = 16'd8;
      step();
      din_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_ready", din_ready, 0);
      chk("t5_en", op_din_en, 0);
      chk("t5_din", op_din, 0);
      chk("t5_frac", fraction, 0);
      chk("t5_done", done, 0);
      #2 rst = 1'b0;
      step();
      chk("t5_nodone", done, 0);
      chk("t5_idle", busy, 0);
      go(16'd2, 16'd1, 16'h0080);
      din_valid = 1'b1; din = 16'd5;
      step();
      chk("t5_eop_a", op_din_eop, 0);
      din = 16'd6;
      step();
      chk("t5_eop_b", op_din_eop, 1);
      chk("t5_din_b", op_din, 6);
      din_valid = 1'b0;
      step();
      step();
      step();
      chk("t5_rv", res_valid, 1);
      step();
      chk("t5_done2", done, 1);
      step();
      chk("t5_busy_off", busy, 0);

      // 6: start while busy is ignored
      go(16'd2, 16'd2, 16'h0100);
      cfg_vec_len = 16'd5; cfg_num_vec = 16'd1; cfg_fraction = 16'h0007;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t6_frac", fraction, 16'h0100);
      chk("t6_busy", busy, 1);
      for (int k = 0; k < 4; k++) begin
         din_valid = 1'b1; din = 16'(20 + k);
         step();
         chk("t6_eop", op_din_eop, (k % 2 == 1));
      end
      din_valid = 1'b0;
      pulses = 0; done_seen = 1'b0;
      for (int c = 0; c < 30 && !done_seen; c++) begin
         step();
         if (res_valid) pulses++;
         if (done) done_seen = 1'b1;
      end
      chk("t6_done_seen", done_seen, 1);
      chk("t6_pulses", pulses, 2);
      chk("t6_frac_end", fraction, 16'h0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
